switch_box_param: RTL
=====================

Name: switch_box_param

Overview:
- Parametrised successor to the two-track switch box element, used in the FPGA routing fabric.
- Carries W tracks per side (N/E/S/W) with unidirectional routing. Each side has separate in/out/oe buses in place of tri-state nets.
- Each output track selects one of three sources: left turn, straight or right turn. Turns can use a Wilton-style track rotation.
- Configuration loads through a serial scan chain into a shadow register and is committed atomically. Each output has an optional pipeline register.

Parameters:
- W, 2, tracks per side (>=1)
- WILTON, 1, 1 = turns rotate track index; 0 = disjoint (turns keep track index)
- ROT, 1, rotation amount for turns when WILTON=1 (0 <= ROT < W)
- CFG_BITS, 12*W, derived, not overridable: 4 sides * W outputs * 3 bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- n_in, e_in, s_in, w_in  in  W  track values entering the box from each side
- n_out, e_out, s_out, w_out  out  W  track values leaving the box on each side
- n_oe, e_oe, s_oe, w_oe  out  W  per-track drive enable for each side
- cfg_en  in  1  shift scan chain one bit this cycle
- cfg_in  in  1  scan data in
- cfg_out  out  1  scan data out, = shadow[CFG_BITS-1]
- cfg_commit  in  1  copy shadow into active config
- cfg_ready  out  1  high when CFG_BITS shifts have occurred since reset or last commit
- cfg_err  out  1  sticky: commit was attempted while cfg_ready=0
- pipe_en  in  1  clock enable for the output pipeline registers

Behaviour:
- Reset (async, rst_n=0) clears: shadow, active, pipe regs, shift counter and cfg_err. All outputs are therefore 0 (oe, out, cfg_out, cfg_ready, cfg_err).
- Side codes: N=0, E=1, S=2, W=3.
- Field for output side s, track t occupies active[(s*W+t)*3 +: 3]. Bits [1:0] = sel, bit [2] = reg.
- sel 00: off. oe=0, out=0.
- sel 01 (left): source side (s+3)%4. Source track (t+ROT)%W if WILTON, else t.
- sel 10 (straight): source side (s+2)%4, track t.
- sel 11 (right): source side (s+1)%4. Source track (t+W-ROT)%W if WILTON, else t.
- oe = (sel != 00), combinational from active config.
- out = reg ? pipe_q : mux. The mux is combinational, with zero-cycle latency from *_in.
- pipe_q <= mux on posedge when pipe_en=1; it holds otherwise. It is not cleared on commit.
- Registered path latency is 1 enabled cycle.
- Shift: when cfg_en=1, shadow <= {shadow[CFG_BITS-2:0], cfg_in}. The counter saturates at CFG_BITS, and cfg_ready = (cnt == CFG_BITS).
- Commit with cfg_ready=1: active <= shadow on that edge, and the counter is cleared. New routing is visible the cycle after.
- Commit with cfg_ready=0: ignored. Active is unchanged and cfg_err is set. cfg_err clears only on reset.
- cfg_en and cfg_commit in the same cycle: commit uses the pre-shift shadow (and is qualified by the pre-shift cfg_ready). After the edge, the counter = 1 if the commit succeeded, otherwise it increments as normal.
- Shifting while cfg_ready=1 keeps cfg_ready=1 (saturated). The last CFG_BITS bits win.
- Active config is unaffected by shifting; routing stays live during reload.
- Reset mid-shift or mid-operation discards the partial load. Routing returns to all-off immediately (async).

Decomposition:
- Package sb_pkg holds:
  - side code constants
  - sel constants (SEL_OFF/LEFT/STRAIGHT/RIGHT)
  - FIELD_W=3
  - function cfg_base(side,track,W)
  - function src_track(sel,t,W,WILTON,ROT)
- Sub-module sb_track_mux: one output. Three source bits, 3-bit field and pipe_en in; out and oe out; contains pipe_q.
- The top level instantiates 4*W copies via generate, plus the scan/commit logic.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all *_oe=0, all *_out=0, cfg_out=0, cfg_ready=0, cfg_err=0 with no clock edge.
- Straight route, W=2: shift 24 bits setting field N0=3'b010, others 0, then commit -> next cycle n_oe=2'b01. n_out[0] follows s_in[0] for s_in toggling 0,1,0 in the same cycle; n_out[1]=0.
- Wilton turn, W=2, ROT=1: E0 field=3'b001 (from N, track 1). n_in=2'b10 -> e_out[0]=1; n_in=2'b01 -> e_out[0]=0. With WILTON=0, n_in=2'b01 -> e_out[0]=1.
- Registered output: N0 field=3'b110. With pipe_en=1, s_in[0] 0->1 at cycle k -> n_out[0]=1 at k+1. With pipe_en=0, n_out[0] holds through an s_in[0] change.
- Early commit: commit after 10 shifts -> active unchanged (oe pattern unchanged), cfg_err=1 and stays 1. 14 further shifts -> cfg_ready=1; commit succeeds.
- Scan passthrough and simultaneous events:
  - Shift pattern 0xA5A5A5 in -> cfg_out reproduces the stream delayed 24 shifts.
  - cfg_en=1 with cfg_commit=1 at cnt=24 -> active = pre-shift shadow, cnt=1 afterwards.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants and elaboration helpers for the parametrised switch box.
// Side/select encodings and config field layout live here.
package sb_pkg;

    localparam int SIDE_N = 0;
    localparam int SIDE_E = 1;
    localparam int SIDE_S = 2;
    localparam int SIDE_W = 3;

    localparam logic [1:0] SEL_OFF      = 2'b00;
    localparam logic [1:0] SEL_LEFT     = 2'b01;
    localparam logic [1:0] SEL_STRAIGHT = 2'b10;
    localparam logic [1:0] SEL_RIGHT    = 2'b11;

    localparam int FIELD_W = 3;

    function automatic int cfg_base(
        input int side,
        input int track,
        input int w
    );
        return (side * w + track) * FIELD_W;
    endfunction

    // Side feeding an output on `side` for a given turn.
    function automatic int src_side(
        input int         side,
        input logic [1:0] sel
    );
        int ofs;
        ofs = 2;
        if (sel == SEL_LEFT) ofs = 3;
        if (sel == SEL_RIGHT) ofs = 1;
        return (side + ofs) % 4;
    endfunction

    function automatic int src_track(
        input logic [1:0] sel,
        input int         t,
        input int         w,
        input int         wilton,
        input int         rot
    );
        int r;
        r = t;
        if (wilton != 0 && sel == SEL_LEFT) r = (t + rot) % w;
        if (wilton != 0 && sel == SEL_RIGHT) r = (t + w - rot) % w;
        return r;
    endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One output track: 3:1 source select, drive enable and optional
// output pipeline register.
module sb_track_mux
    import sb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         src,
    input  logic [FIELD_W-1:0] field,
    input  logic               pipe_en,
    output logic               out,
    output logic               oe
);

    logic [1:0] sel;
    logic       use_reg;
    logic       mux;
    logic       pipe_q;

    assign sel     = field[1:0];
    assign use_reg = field[2];

    // src[0]=left, src[1]=straight, src[2]=right
    always_comb begin
        mux = 1'b0;
        unique case (sel)
            SEL_LEFT:     mux = src[0];
            SEL_STRAIGHT: mux = src[1];
            SEL_RIGHT:    mux = src[2];
            default:      mux = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= 1'b0;
        end else if (pipe_en) begin
            pipe_q <= mux;
        end
    end

    // An unselected track never drives, even with a stale pipe value.
    assign oe  = (sel != SEL_OFF);
    assign out = oe & (use_reg ? pipe_q : mux);

endmodule

// File: rtl/switch_box_param.sv
// W-track unidirectional switch box with scan-loaded shadow config,
// atomic commit and per-output pipeline registers.
module switch_box_param
    import sb_pkg::*;
#(
    parameter int W      = 2,
    parameter int WILTON = 1,
    parameter int ROT    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] e_in,
    input  logic [W-1:0] s_in,
    input  logic [W-1:0] w_in,
    output logic [W-1:0] n_out,
    output logic [W-1:0] e_out,
    output logic [W-1:0] s_out,
    output logic [W-1:0] w_out,
    output logic [W-1:0] n_oe,
    output logic [W-1:0] e_oe,
    output logic [W-1:0] s_oe,
    output logic [W-1:0] w_oe,
    input  logic         cfg_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    input  logic         cfg_commit,
    output logic         cfg_ready,
    output logic         cfg_err,
    input  logic         pipe_en
);

    localparam int CFG_BITS = 4 * W * FIELD_W;
    localparam int CW       = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);

    if (W < 1 || (WILTON != 0 && (ROT < 0 || ROT >= W))) begin : g_bad_param
        $error("switch_box_param: illegal W/ROT combination");
    end

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CW-1:0]       cnt;
    logic                err_q;
    logic                commit_ok;

    logic [4*W-1:0] in_flat;
    logic [4*W-1:0] out_flat;
    logic [4*W-1:0] oe_flat;

    assign in_flat[SIDE_N*W +: W] = n_in;
    assign in_flat[SIDE_E*W +: W] = e_in;
    assign in_flat[SIDE_S*W +: W] = s_in;
    assign in_flat[SIDE_W*W +: W] = w_in;

    assign n_out = out_flat[SIDE_N*W +: W];
    assign e_out = out_flat[SIDE_E*W +: W];
    assign s_out = out_flat[SIDE_S*W +: W];
    assign w_out = out_flat[SIDE_W*W +: W];

    assign n_oe = oe_flat[SIDE_N*W +: W];
    assign e_oe = oe_flat[SIDE_E*W +: W];
    assign s_oe = oe_flat[SIDE_S*W +: W];
    assign w_oe = oe_flat[SIDE_W*W +: W];

    assign cfg_ready = (cnt == CNT_FULL);
    assign cfg_out   = shadow[CFG_BITS-1];
    assign cfg_err   = err_q;
    assign commit_ok = cfg_commit & cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (cfg_en) begin
            shadow <= {shadow[CFG_BITS-2:0], cfg_in};
        end
    end

    // Commit samples the pre-shift shadow; a same-cycle shift counts as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
            cnt    <= '0;
        end else if (commit_ok) begin
            active <= shadow;
            cnt    <= cfg_en ? CW'(1) : '0;
        end else if (cfg_en && !cfg_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (cfg_commit && !cfg_ready) begin
            err_q <= 1'b1;
        end
    end

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < W; t++) begin : g_trk
            localparam int LI = src_side(s, SEL_LEFT) * W
                + src_track(SEL_LEFT, t, W, WILTON, ROT);
            localparam int SI = src_side(s, SEL_STRAIGHT) * W + t;
            localparam int RI = src_side(s, SEL_RIGHT) * W
                + src_track(SEL_RIGHT, t, W, WILTON, ROT);

            sb_track_mux u_mux (
                .clk     (clk),
                .rst_n   (rst_n),
                .src     ({in_flat[RI], in_flat[SI], in_flat[LI]}),
                .field   (active[cfg_base(s, t, W) +: FIELD_W]),
                .pipe_en (pipe_en),
                .out     (out_flat[s*W+t]),
                .oe      (oe_flat[s*W+t])
            );
        end
    end

endmodule
